// File: rtl/display_scan_ctrl_if.sv
// Load handshake between a value producer and the display scan controller.
interface display_scan_ctrl_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  // Producer side: offers a new 4-digit BCD value.
  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  // Consumer side: the scan controller.
  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered value
// and optional leading-zero blanking. Outputs are registered and active-low.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                lz_blank,
  display_scan_ctrl_if.slave  load,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                frame_done
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  localparam logic [3:0] AnDark  = 4'b1111;
  localparam logic [6:0] SegDark = 7'b1111111;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     active_q, active_d;
  logic [15:0]     pending_q, pending_d;
  logic            pfull_q, pfull_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_q, frame_d;
  logic            accept;
  logic            load_digit;

  // Segment pattern for digit k of val; blank covers non-BCD nibbles and leading zeros.
  function automatic logic [6:0] digit_seg(input logic [15:0] val, input logic [1:0] k,
                                           input logic lz);
    logic [3:0]  nib;
    logic [15:0] upper;
    logic [6:0]  pat;
    nib   = val[{k, 2'b00} +: 4];
    upper = val >> {k, 2'b00};
    unique case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      default: pat = SegDark;
    endcase
    // Digit 0 always shows so a zero value still displays "0".
    if (lz && (k != 2'd0) && (upper == 16'h0000)) begin
      pat = SegDark;
    end
    return pat;
  endfunction

  assign load.load_ready = !pfull_q;
  assign accept          = load.load_valid && !pfull_q;

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_q;

  // Next-state: scan sequencing, buffer management and registered digit drive.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pfull_d    = pfull_q;
    an_d       = an_q;
    seg_d      = seg_q;
    frame_d    = 1'b0;
    load_digit = 1'b0;

    unique case (state_q)
      StIdle: begin
        an_d  = AnDark;
        seg_d = SegDark;
        cnt_d = '0;
        idx_d = 2'd0;
        if (pfull_q) begin
          active_d = pending_q;
          pfull_d  = 1'b0;
        end
        // Nothing is being scanned, so new data goes straight to the display buffer.
        if (accept) begin
          active_d = load.load_data;
        end
        if (enable) begin
          state_d    = StScan;
          load_digit = 1'b1;
        end
      end

      StScan: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = 2'd0;
          an_d    = AnDark;
          seg_d   = SegDark;
          if (pfull_q) begin
            active_d = pending_q;
            pfull_d  = 1'b0;
          end
          // Leaving the scan: treat a same-edge load as an idle load.
          if (accept) begin
            active_d = load.load_data;
          end
        end else begin
          if (cnt_q == CntMax) begin
            cnt_d      = '0;
            idx_d      = idx_q + 2'd1;
            load_digit = 1'b1;
            // Swap buffers only between frames so a frame never mixes two values.
            if (idx_q == 2'd3) begin
              frame_d = 1'b1;
              if (pfull_q) begin
                active_d = pending_q;
                pfull_d  = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (accept) begin
            pending_d = load.load_data;
            pfull_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        an_d    = AnDark;
        seg_d   = SegDark;
      end
    endcase

    // Use active_d so the digit lit on a wrap edge already shows the new value.
    if (load_digit) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = digit_seg(active_d, idx_d, lz_blank);
    end
  end

  // State registers; reset forces a dark display and empty buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      active_q  <= 16'h0000;
      pending_q <= 16'h0000;
      pfull_q   <= 1'b0;
      an_q      <= AnDark;
      seg_q     <= SegDark;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pfull_q   <= pfull_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

endmodule
